dmem_write_capture: RTL and testbench
=====================================

Name: dmem_write_capture

Overview:
- Responder on the MIPS data-memory write interface (memwrite, dataadr, writedata) driven by `top`.
- Captures stores that fall in a result window into a FIFO and drains them over a valid/ready stream to a host-side consumer.
- Decodes a pass/fail completion store, turning the bench's manual store watching into synthesizable on-chip result collection.

Parameters:
- WIN_BASE, 32'h0000_0100, byte address of capture window start; word aligned.
- WIN_WORDS, 16, window size in words; power of two, 1..256.
- DEPTH, 8, FIFO entries; power of two, 2..64.
- DONE_ADDR, 32'h0000_0054, byte address whose store ends the test.
- PASS_VALUE, 32'd7, store data at DONE_ADDR meaning pass.

Ports:
- clk  in  1  system clock, rising edge.
- reset  in  1  synchronous, active-high.
- clr  in  1  synchronous soft clear of FIFO, flags and counters; reset dominates.
- memwrite  in  1  core store strobe, one cycle per store.
- dataadr  in  32  store byte address.
- writedata  in  32  store data.
- cap_valid  out  1  FIFO head valid.
- cap_ready  in  1  consumer accepts head.
- cap_offset  out  8  word offset of head within window, (addr-WIN_BASE)>>2.
- cap_data  out  32  head data.
- cap_time  out  16  head timestamp; see Optional Feature.
- cap_count  out  7  FIFO occupancy, 0..DEPTH.
- drop_count  out  16  window stores dropped while full; saturates at 16'hFFFF.
- overflow  out  1  sticky: at least one drop.
- misalign  out  1  sticky: store with dataadr[1:0]!=0 inside the window range.
- done  out  1  sticky: completion store seen.
- pass  out  1  sticky: done and data==PASS_VALUE.
- fail  out  1  sticky: done and data!=PASS_VALUE.

Behaviour:
- Reset or clr: FIFO empty, so cap_valid=0. cap_count=0, drop_count=0. overflow, misalign, done, pass and fail all 0. cap_offset, cap_data and cap_time read 0.
- hit = memwrite & WIN_BASE <= dataadr < WIN_BASE+4*WIN_WORDS & dataadr[1:0]==0. Compare unsigned, full 32 bits, no wrap.
- Misaligned in-range store: not captured; sets misalign.
- pop = cap_valid & cap_ready.
- push = hit & (cap_count<DEPTH | pop). A simultaneous push and pop when full is accepted; occupancy is unchanged.
- FIFO is first-word-fall-through: a store written on edge N is visible on cap_* after edge N (latency 1 cycle). It stays stable while cap_valid & !cap_ready.
- Pointers wrap modulo DEPTH. cap_count is updated the same edge as push/pop.
- Drop: hit & !push, i.e. full with no pop. Data is discarded, drop_count increments (saturating) and overflow is set.
- Done decode: memwrite & dataadr==DONE_ADDR & !done sets done on that edge.
  - pass = (writedata==PASS_VALUE); fail is the complement.
  - The first completion store wins. Later stores to DONE_ADDR are ignored until reset or clr.
  - pass and fail are never both 1.
- If DONE_ADDR lies inside the window, the store is both captured and decoded.
- memwrite=0: no state change except pop.
- Reset or clr mid-drain: contents are lost. cap_valid drops the cycle after the edge.
- No combinational path from memwrite/dataadr to cap_valid. cap_ready feeds only push/pop logic.

Optional Feature:
- Macro: CAPTURE_TIMESTAMP_EN.
- Defined:
  - 16-bit free-running cycle counter, cleared by reset/clr, wraps 16'hFFFF->0.
  - Each pushed entry stores the counter value of the push cycle; cap_time presents the head entry's stamp.
  - FIFO width is 8+32+16.
- Undefined: no counter; cap_time tied 16'h0; FIFO width is 8+32.
- The port list is identical in both builds.

Test Plan:
- Reset, then stores 0x100<-3, 0x104<-5, 0x13C<-9 with cap_ready=0 -> cap_count=3. Head is offset 0/data 3. Raising cap_ready drains offsets 0,1,15 with data 3,5,9; count reaches 0.
- cap_ready=0, 10 window stores (DEPTH=8) -> cap_count=8, drop_count=2, overflow=1. Drained data equals the first 8 stores in order.
- FIFO full with cap_ready=1 and a store 0x108<-0xAA the same cycle -> cap_count stays 8, drop_count unchanged, 0xAA appears last.
- Stores 0x0FC<-1, 0x140<-1 (out of range) and 0x102<-1 (misaligned) -> nothing captured; misalign=1 only after 0x102.
- Store 0x54<-7 then 0x54<-8 -> done=1, pass=1, fail=0, unchanged by the second store. After clr, store 0x54<-8 -> done=1, fail=1.
- CAPTURE_TIMESTAMP_EN defined: reset released, first window store 5 cycles later -> cap_time=5. Undefined: cap_time=0 always.

Source files
------------

// File: rtl/dmem_write_capture.sv
// dmem_write_capture: captures data-memory stores that land in a result window into a FWFT FIFO
// and decodes a pass/fail completion store. Optional macro: CAPTURE_TIMESTAMP_EN (per-entry cycle stamp).
`default_nettype none
`timescale 1ns/1ps

module dmem_write_capture #(
  parameter logic [31:0] WIN_BASE   = 32'h0000_0100,
  parameter int          WIN_WORDS  = 16,
  parameter int          DEPTH      = 8,
  parameter logic [31:0] DONE_ADDR  = 32'h0000_0054,
  parameter logic [31:0] PASS_VALUE = 32'd7
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        clr,
  input  logic        memwrite,
  input  logic [31:0] dataadr,
  input  logic [31:0] writedata,
  output logic        cap_valid,
  input  logic        cap_ready,
  output logic [7:0]  cap_offset,
  output logic [31:0] cap_data,
  output logic [15:0] cap_time,
  output logic [6:0]  cap_count,
  output logic [15:0] drop_count,
  output logic        overflow,
  output logic        misalign,
  output logic        done,
  output logic        pass,
  output logic        fail
);

  localparam int          AW      = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [6:0]  DEPTH_C = 7'(DEPTH);
  // One bit wider than the address so a window touching the top of memory cannot wrap.
  localparam logic [32:0] WIN_END = {1'b0, WIN_BASE} + 33'(4 * WIN_WORDS);
`ifdef CAPTURE_TIMESTAMP_EN
  localparam int          EW      = 8 + 32 + 16;
`else
  localparam int          EW      = 8 + 32;
`endif

  logic [EW-1:0] mem [DEPTH];
  logic [AW-1:0] wr_ptr, rd_ptr;
  logic [6:0]    count;
  logic [EW-1:0] entry_in, head;
  logic [7:0]    offset;
  logic          in_range, hit, pop, push, drop, soft_rst;

  assign soft_rst  = reset || clr;
  assign cap_valid = (count != 7'd0);
  assign cap_count = count;
  assign head      = mem[rd_ptr];

  always_comb begin
    in_range = (dataadr >= WIN_BASE) && ({1'b0, dataadr} < WIN_END);
    hit      = memwrite && in_range && (dataadr[1:0] == 2'b00);
    pop      = cap_valid && cap_ready;
    push     = hit && ((count < DEPTH_C) || pop);
    drop     = hit && !push;
    offset   = 8'((dataadr - WIN_BASE) >> 2);
  end

`ifdef CAPTURE_TIMESTAMP_EN
  logic [15:0] stamp;

  always_ff @(posedge clk) begin
    if (soft_rst) stamp <= 16'h0;
    else          stamp <= stamp + 16'h1;
  end

  assign entry_in = {offset, writedata, stamp};
  assign cap_time = cap_valid ? head[15:0] : 16'h0;
`else
  assign entry_in = {offset, writedata};
  assign cap_time = 16'h0;
`endif

  // Empty FIFO presents zeros rather than stale storage contents.
  assign cap_offset = cap_valid ? head[EW-1 -: 8]  : 8'h0;
  assign cap_data   = cap_valid ? head[EW-9 -: 32] : 32'h0;

  always_ff @(posedge clk) begin
    if (!soft_rst && push) mem[wr_ptr] <= entry_in;
  end

  always_ff @(posedge clk) begin
    if (soft_rst) begin
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      count      <= 7'd0;
      drop_count <= 16'h0;
      overflow   <= 1'b0;
      misalign   <= 1'b0;
      done       <= 1'b0;
      pass       <= 1'b0;
      fail       <= 1'b0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
      count <= count + 7'(push) - 7'(pop);
      if (drop) begin
        overflow <= 1'b1;
        if (drop_count != 16'hFFFF) drop_count <= drop_count + 16'h1;
      end
      if (memwrite && in_range && (dataadr[1:0] != 2'b00)) misalign <= 1'b1;
      // First completion store wins; later ones are ignored until cleared.
      if (memwrite && (dataadr == DONE_ADDR) && !done) begin
        done <= 1'b1;
        pass <= (writedata == PASS_VALUE);
        fail <= (writedata != PASS_VALUE);
      end
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_dmem_write_capture.sv
// tb_dmem_write_capture: directed test-plan steps followed by random stores, checked each cycle
// against a queue-based reference model of the capture window, FIFO and completion decode.
`default_nettype none
`timescale 1ns/1ps

module tb_dmem_write_capture;

  localparam logic [31:0] BASE  = 32'h0000_0100;
  localparam int          WORDS = 16;
  localparam int          DEPTH = 8;
  localparam logic [31:0] DONEA = 32'h0000_0054;
  localparam logic [31:0] PASSV = 32'd7;

  logic        clk = 1'b0;
  logic        reset, clr, memwrite, cap_ready;
  logic [31:0] dataadr, writedata;
  logic        cap_valid, overflow, misalign, done, pass, fail;
  logic [7:0]  cap_offset;
  logic [31:0] cap_data;
  logic [15:0] cap_time, drop_count;
  logic [6:0]  cap_count;

  always #5 clk = ~clk;

  dmem_write_capture dut (
    .clk(clk), .reset(reset), .clr(clr), .memwrite(memwrite), .dataadr(dataadr),
    .writedata(writedata), .cap_valid(cap_valid), .cap_ready(cap_ready),
    .cap_offset(cap_offset), .cap_data(cap_data), .cap_time(cap_time),
    .cap_count(cap_count), .drop_count(drop_count), .overflow(overflow),
    .misalign(misalign), .done(done), .pass(pass), .fail(fail)
  );

  typedef struct {
    logic [7:0]  off;
    logic [31:0] data;
    logic [15:0] ts;
  } ent_t;

  ent_t        q[$];
  int          m_drop;
  bit          m_ovf, m_mis, m_done, m_pass, m_fail;
  logic [15:0] m_tick;
  int          errors = 0;
  int          checks = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic model_clear();
    q.delete();
    m_drop = 0;
    m_ovf = 0; m_mis = 0; m_done = 0; m_pass = 0; m_fail = 0;
    m_tick = 16'h0;
  endtask

  task automatic check_all();
    logic [7:0]  e_off;
    logic [31:0] e_data;
    logic [15:0] e_time;
    e_off = 8'h0; e_data = 32'h0; e_time = 16'h0;
    if (q.size() != 0) begin
      e_off  = q[0].off;
      e_data = q[0].data;
`ifdef CAPTURE_TIMESTAMP_EN
      e_time = q[0].ts;
`endif
    end
    chk("cap_valid",  cap_valid,  32'(q.size() != 0));
    chk("cap_count",  cap_count,  32'(q.size()));
    chk("cap_offset", cap_offset, e_off);
    chk("cap_data",   cap_data,   e_data);
    chk("cap_time",   cap_time,   e_time);
    chk("drop_count", drop_count, 32'(m_drop));
    chk("overflow",   overflow,   m_ovf);
    chk("misalign",   misalign,   m_mis);
    chk("done",       done,       m_done);
    chk("pass",       pass,       m_pass);
    chk("fail",       fail,       m_fail);
  endtask

  // One clock: drive inputs, advance the model by the same rules, then compare after the edge.
  task automatic step(input bit mw, input logic [31:0] a, input logic [31:0] d,
                      input bit rdy, input bit rs, input bit cl);
    longint ua;
    bit     inr;
    ent_t   e;
    reset = rs; clr = cl; memwrite = mw; dataadr = a; writedata = d; cap_ready = rdy;
    if (rs || cl) begin
      model_clear();
    end else begin
      ua  = longint'(a);
      inr = (ua >= longint'(BASE)) && (ua < longint'(BASE) + 4 * WORDS);
      if (rdy && q.size() > 0) void'(q.pop_front());
      if (mw && inr && (a % 4 == 0)) begin
        if (q.size() < DEPTH) begin
          e.off = 8'((ua - longint'(BASE)) / 4); e.data = d; e.ts = m_tick;
          q.push_back(e);
        end else begin
          if (m_drop < 65535) m_drop++;
          m_ovf = 1;
        end
      end
      if (mw && inr && (a % 4 != 0)) m_mis = 1;
      if (mw && a == DONEA && !m_done) begin
        m_done = 1;
        m_pass = (d == PASSV);
        m_fail = (d != PASSV);
      end
      m_tick = m_tick + 16'h1;
    end
    @(posedge clk);
    #1;
    check_all();
  endtask

  task automatic st(input logic [31:0] a, input logic [31:0] d, input bit rdy);
    step(1'b1, a, d, rdy, 1'b0, 1'b0);
  endtask

  task automatic idle(input bit rdy);
    step(1'b0, 32'h0, 32'h0, rdy, 1'b0, 1'b0);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  initial begin
    logic [31:0] a, d;
    int          r;
    model_clear();
    step(1'b0, 32'h0, 32'h0, 1'b0, 1'b1, 1'b0);
    step(1'b0, 32'h0, 32'h0, 1'b0, 1'b1, 1'b0);
    chk("rst_valid", cap_valid, 0);
    chk("rst_count", cap_count, 0);

    // Three stores held, then drained in order.
    st(32'h100, 32'd3, 1'b0);
    st(32'h104, 32'd5, 1'b0);
    st(32'h13C, 32'd9, 1'b0);
    chk("tp1_count", cap_count, 3);
    chk("tp1_head_off", cap_offset, 0);
    chk("tp1_head_data", cap_data, 3);
    idle(1'b1);
    chk("tp1_h1_off", cap_offset, 1);
    idle(1'b1);
    chk("tp1_h2_off", cap_offset, 15);
    chk("tp1_h2_data", cap_data, 9);
    idle(1'b1);
    chk("tp1_empty", cap_count, 0);

    // Ten stores into an eight-deep FIFO.
    for (int i = 0; i < 10; i++) st(BASE + 32'(4 * i), 32'h1000 + 32'(i), 1'b0);
    chk("tp2_count", cap_count, 8);
    chk("tp2_drops", drop_count, 2);
    chk("tp2_ovf", overflow, 1);

    // Full, popping and pushing on the same edge.
    st(32'h108, 32'hAA, 1'b1);
    chk("tp3_count", cap_count, 8);
    chk("tp3_drops", drop_count, 2);
    for (int i = 0; i < 7; i++) idle(1'b1);
    chk("tp3_last", cap_data, 32'hAA);
    idle(1'b1);

    // Out-of-range and misaligned stores.
    step(1'b0, 32'h0, 32'h0, 1'b0, 1'b1, 1'b0);
    st(32'h0FC, 32'd1, 1'b0);
    st(32'h140, 32'd1, 1'b0);
    chk("tp4_mis_before", misalign, 0);
    st(32'h102, 32'd1, 1'b0);
    chk("tp4_mis_after", misalign, 1);
    chk("tp4_count", cap_count, 0);

    // Completion decode: first store wins, clr re-arms.
    st(DONEA, 32'd7, 1'b0);
    st(DONEA, 32'd8, 1'b0);
    chk("tp5_done", done, 1);
    chk("tp5_pass", pass, 1);
    chk("tp5_fail", fail, 0);
    step(1'b0, 32'h0, 32'h0, 1'b0, 1'b0, 1'b1);
    st(DONEA, 32'd8, 1'b0);
    chk("tp5_fail2", fail, 1);
    chk("tp5_pass2", pass, 0);

    // Timestamp of a store five cycles after reset release.
    step(1'b0, 32'h0, 32'h0, 1'b0, 1'b1, 1'b0);
    for (int i = 0; i < 5; i++) idle(1'b0);
    st(32'h100, 32'h55, 1'b0);
`ifdef CAPTURE_TIMESTAMP_EN
    chk("tp6_time", cap_time, 5);
`else
    chk("tp6_time", cap_time, 0);
`endif
    step(1'b0, 32'h0, 32'h0, 1'b0, 1'b0, 1'b1);

    // Random traffic.
    for (int n = 0; n < 600; n++) begin
      r = int'($urandom_range(0, 5));
      case (r)
        0, 1:    a = BASE + 32'(4 * $urandom_range(0, WORDS - 1));
        2:       a = BASE + 32'(4 * $urandom_range(0, WORDS - 1)) + 32'($urandom_range(1, 3));
        3:       a = ($urandom_range(0, 1) != 0) ? BASE - 32'd4 : BASE + 32'(4 * WORDS);
        4:       a = DONEA;
        default: a = $urandom;
      endcase
      d = ($urandom_range(0, 1) != 0) ? PASSV : $urandom;
      step(($urandom_range(0, 3) != 0), a, d, ($urandom_range(0, 9) < 4),
           1'b0, ($urandom_range(0, 99) < 2));
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

`default_nettype wire
